// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared widths, defaults and request bundle for mem_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int ADDR_W             = 30;
    localparam int DATA_W             = 32;
    localparam int STRB_W             = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : arb_starve_cnt
//  Description : Saturating count of cycles m0 waits; raises force when full.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_m0_req,
    input  logic i_m0_gnt,
    output logic o_force_m0
);

    localparam int              CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = '0;
        if (i_m0_req && !i_m0_gnt) begin
            w_cnt_d = (r_cnt_q == C_MAX) ? r_cnt_q : r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_force_m0 = (r_cnt_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port single-cycle memory arbiter, m1 priority with m0
//                starvation guard; read data returns one cycle after grant.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_rready,
    output logic              mem_wready,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic     w_force_m0;
    logic     w_m0_gnt;
    logic     w_m1_gnt;
    logic     w_any_gnt;
    mem_req_t w_m0_fields;
    mem_req_t w_m1_fields;
    mem_req_t w_sel;
    logic     r_m0_rvalid_q;
    logic     r_m1_rvalid_q;
    logic     w_m0_rvalid_d;
    logic     w_m1_rvalid_d;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_m0_req   (m0_req),
        .i_m0_gnt   (w_m0_gnt),
        .o_force_m0 (w_force_m0)
    );

    assign w_m0_gnt  = !reset && m0_req && (w_force_m0 || !m1_req);
    assign w_m1_gnt  = !reset && m1_req && !w_m0_gnt;
    assign w_any_gnt = w_m0_gnt || w_m1_gnt;

    assign w_m0_fields = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign w_m1_fields = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
    // Idle buses park on m1 so the common load/store path needs no extra mux state.
    assign w_sel       = w_m0_gnt ? w_m0_fields : w_m1_fields;

    assign m0_gnt     = w_m0_gnt;
    assign m1_gnt     = w_m1_gnt;
    assign mem_rready = w_any_gnt && !w_sel.we;
    assign mem_wready = w_any_gnt && w_sel.we;
    assign mem_raddr  = w_sel.addr;
    assign mem_waddr  = w_sel.addr;
    assign mem_wdata  = w_sel.wdata;
    assign mem_wstrb  = w_sel.wstrb;

    always_comb begin
        w_m0_rvalid_d = w_m0_gnt && !m0_we;
        w_m1_rvalid_d = w_m1_gnt && !m1_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m0_rvalid_q <= 1'b0;
            r_m1_rvalid_q <= 1'b0;
        end else begin
            r_m0_rvalid_q <= w_m0_rvalid_d;
            r_m1_rvalid_q <= w_m1_rvalid_d;
        end
    end

    // A read granted just before reset must not surface while reset is held.
    assign m0_rvalid = r_m0_rvalid_q && !reset;
    assign m1_rvalid = r_m1_rvalid_q && !reset;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed and randomised self-checking bench for mem_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int C_STARVE = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              mem_rready, mem_wready;
    logic [ADDR_W-1:0] mem_raddr, mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:1023];

    mem_arbiter #(.STARVE_MAX(C_STARVE)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_rready(mem_rready), .mem_wready(mem_wready), .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: byte-strobed writes, read data visible the cycle after rready.
    always @(posedge clk) begin
        if (mem_wready) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem[mem_waddr[9:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
        if (mem_rready) mem_rdata <= mem[mem_raddr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        exp_g0, exp_g1;
        logic [31:0] exp_addr;
        int          cnt_m;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
        mem_rdata = '0;
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h10; m0_wdata = '0; m0_wstrb = 4'hF;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 30'h20; m1_wdata = '0; m1_wstrb = 4'hF;

        // Reset with both requesting
        tick(); tick();
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_rready", mem_rready, 0);
        chk("rst_wready", mem_wready, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);

        // Idle: buses carry m1 fields
        reset = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        m1_addr = 30'h55; m1_wdata = 32'h1234_5678;
        #1;
        chk("idle_m0_gnt", m0_gnt, 0);
        chk("idle_m1_gnt", m1_gnt, 0);
        chk("idle_rready", mem_rready, 0);
        chk("idle_raddr", mem_raddr, 30'h55);
        chk("idle_wdata", mem_wdata, 32'h1234_5678);

        // m0 read alone
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h100;
        #1;
        chk("m0rd_gnt", m0_gnt, 1);
        chk("m0rd_m1_gnt", m1_gnt, 0);
        chk("m0rd_rready", mem_rready, 1);
        chk("m0rd_wready", mem_wready, 0);
        chk("m0rd_raddr", mem_raddr, 30'h100);
        tick();
        chk("m0rd_rvalid", m0_rvalid, 1);
        chk("m0rd_rdata", m0_rdata, 32'hC0DE_0100);
        chk("m0rd_m1_rvalid", m1_rvalid, 0);
        m0_req = 1'b0;
        #1;
        chk("m0rd_idle_rready", mem_rready, 0);
        tick();
        chk("m0rd_rvalid_once", m0_rvalid, 0);

        // m1 partial write then read-back
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 30'h40; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b0011;
        #1;
        chk("m1wr_gnt", m1_gnt, 1);
        chk("m1wr_m0_gnt", m0_gnt, 0);
        chk("m1wr_wready", mem_wready, 1);
        chk("m1wr_rready", mem_rready, 0);
        chk("m1wr_waddr", mem_waddr, 30'h40);
        chk("m1wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("m1wr_wstrb", mem_wstrb, 4'b0011);
        tick();
        chk("m1wr_no_rvalid", m1_rvalid, 0);
        m1_we = 1'b0;
        #1;
        chk("m1rd_gnt", m1_gnt, 1);
        chk("m1rd_rready", mem_rready, 1);
        tick();
        chk("m1rd_rvalid", m1_rvalid, 1);
        chk("m1rd_rdata", m1_rdata, 32'hC0DE_BEEF);

        // m0 write with zero strobes still granted, memory untouched
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 30'h41; m0_wdata = 32'hFFFF_FFFF; m0_wstrb = 4'b0000;
        #1;
        chk("m0wr0_gnt", m0_gnt, 1);
        chk("m0wr0_wready", mem_wready, 1);
        chk("m0wr0_wstrb", mem_wstrb, 4'b0000);
        tick();
        chk("m0wr0_no_rvalid", m0_rvalid, 0);
        m0_we = 1'b0;
        #1;
        chk("m0rd41_gnt", m0_gnt, 1);
        tick();
        chk("m0rd41_rvalid", m0_rvalid, 1);
        chk("m0rd41_rdata", m0_rdata, 32'hC0DE_0041);
        chk("m0rd41_m1_rvalid", m1_rvalid, 0);

        // Continuous contention: four m1 grants then one forced m0 grant
        m0_addr = 30'h10; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 30'h20;
        for (int k = 0; k < 15; k++) begin
            #1;
            chk("starve_m0_gnt", m0_gnt, (k % 5) == 4);
            chk("starve_m1_gnt", m1_gnt, (k % 5) != 4);
            tick();
            chk("starve_m0_rvalid", m0_rvalid, (k % 5) == 4);
            chk("starve_m1_rvalid", m1_rvalid, (k % 5) != 4);
            chk("starve_rdata", m0_rdata, ((k % 5) == 4) ? 32'hC0DE_0010 : 32'hC0DE_0020);
        end

        // Build up starvation, then reset must clear it
        repeat (3) begin
            #1;
            chk("prerst_m1_gnt", m1_gnt, 1);
            tick();
        end
        reset = 1'b1;
        #1;
        chk("rst2_m0_gnt", m0_gnt, 0);
        chk("rst2_m1_gnt", m1_gnt, 0);
        chk("rst2_m1_rvalid", m1_rvalid, 0);
        tick();
        chk("rst2_m1_rvalid_b", m1_rvalid, 0);
        chk("rst2_m0_gnt_b", m0_gnt, 0);
        tick();
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("postrst_m0_gnt", m0_gnt, j == 4);
            chk("postrst_m1_gnt", m1_gnt, j != 4);
            tick();
        end

        // m0 read granted, reset asserted the following cycle
        m1_req = 1'b0; m0_addr = 30'h100;
        #1;
        chk("rdrst_gnt", m0_gnt, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("rdrst_rvalid", m0_rvalid, 0);
        chk("rdrst_gnt_low", m0_gnt, 0);
        chk("rdrst_rready", mem_rready, 0);
        tick();
        chk("rdrst_rvalid_b", m0_rvalid, 0);
        reset = 1'b0;
        m0_req = 1'b0;
        tick();

        // Random read traffic against a small reference arbiter
        cnt_m = 0;
        exp_addr = '0;
        m0_we = 1'b0; m1_we = 1'b0;
        m0_req = 1'($urandom_range(1, 0)); m0_addr = 30'($urandom_range(255, 128));
        m1_req = 1'($urandom_range(1, 0)); m1_addr = 30'($urandom_range(255, 128));
        for (int r = 0; r < 100; r++) begin
            #1;
            exp_g0 = m0_req && (cnt_m == C_STARVE || !m1_req);
            exp_g1 = m1_req && !exp_g0;
            exp_addr = exp_g0 ? 32'(m0_addr) : 32'(m1_addr);
            cnt_m = (m0_req && !exp_g0) ? ((cnt_m == C_STARVE) ? C_STARVE : cnt_m + 1) : 0;
            chk("rnd_m0_gnt", m0_gnt, exp_g0);
            chk("rnd_m1_gnt", m1_gnt, exp_g1);
            chk("rnd_one_gnt", m0_gnt & m1_gnt, 0);
            tick();
            chk("rnd_m0_rvalid", m0_rvalid, exp_g0);
            chk("rnd_m1_rvalid", m1_rvalid, exp_g1);
            if (exp_g0 || exp_g1) chk("rnd_rdata", m0_rdata, 32'hC0DE_0000 | exp_addr);
            if (!m0_req || exp_g0) begin
                m0_req = 1'($urandom_range(1, 0)); m0_addr = 30'($urandom_range(255, 128));
            end
            if (!m1_req || exp_g1) begin
                m1_req = 1'($urandom_range(1, 0)); m1_addr = 30'($urandom_range(255, 128));
            end
        end

        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
